// File: rtl/cpu0_pkg.sv
// Shared cpu0 definitions: opcodes, scheduler FSM encoding, accepted-issue record.
package cpu0_pkg;

  localparam logic [3:0] OP_JUMP = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic        src;    // 0 = fetch, 1 = debug
  } issue_t;

  function automatic logic [3:0] opcode(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/cpu0_rr_arb2.sv
// Two-way arbiter: round-robin against the last grant, or fixed debug priority.
module cpu0_rr_arb2 #(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,   // [0] fetch, [1] debug
  input  logic       last,  // source of the last transfer
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (RR_EN != 0) gnt = last ? 2'b01 : 2'b10;
        else            gnt = 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cpu0_fetch_sched.sv
// Instruction scheduler: arbitrates fetch/debug requesters into a single CPU issue
// stream, handling JUMP flush windows and HALT.
module cpu0_fetch_sched
  import cpu0_pkg::*;
#(
  parameter int RR_EN        = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        pon_rst_n_i,
  input  logic [15:0] fetch_instr_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [15:0] dbg_instr_i,
  input  logic        dbg_valid_i,
  output logic        dbg_ready_o,
  input  logic        cpu_halt_i,
  output logic [15:0] instr_o,
  output logic        instr_valid_o,
  output logic        grant_src_o,
  output logic        flush_o,
  output logic [12:0] flush_adr_o,
  output logic [15:0] issue_cnt_o,
  output logic [1:0]  state_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  sched_state_e state, state_nxt;
  logic         rr_last;
  logic [3:0]   flush_cnt;
  logic [1:0]   gnt;
  logic         can_issue, xfer, is_jump, is_halt;
  issue_t       acc;

  cpu0_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .req  ({dbg_valid_i, fetch_valid_i}),
    .last (rr_last),
    .gnt  (gnt)
  );

  assign can_issue     = (state == ST_ISSUE) && !cpu_halt_i;
  assign fetch_ready_o = can_issue & gnt[0];
  assign dbg_ready_o   = can_issue & gnt[1];
  assign xfer          = (fetch_valid_i & fetch_ready_o) | (dbg_valid_i & dbg_ready_o);
  assign acc.src       = dbg_ready_o;
  assign acc.instr     = dbg_ready_o ? dbg_instr_i : fetch_instr_i;
  assign is_jump       = xfer && (opcode(acc.instr) == OP_JUMP);
  assign is_halt       = xfer && (opcode(acc.instr) == OP_HALT);
  assign state_o       = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (is_jump)      state_nxt = ST_FLUSH;
        else if (is_halt) state_nxt = ST_HALTED;
      end
      ST_FLUSH:  if (flush_cnt == 4'd0) state_nxt = ST_ISSUE;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
    // External halt overrides everything, including an in-progress flush.
    if (cpu_halt_i) state_nxt = ST_HALTED;
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i)                                flush_cnt <= 4'd0;
    else if (cpu_halt_i)                             flush_cnt <= 4'd0;
    else if (is_jump)                                flush_cnt <= FLUSH_LOAD;
    else if (state == ST_FLUSH && flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      instr_o       <= 16'h0000;
      instr_valid_o <= 1'b0;
      grant_src_o   <= 1'b0;
      flush_o       <= 1'b0;
      flush_adr_o   <= 13'h0000;
      issue_cnt_o   <= 16'h0000;
      rr_last       <= 1'b1;  // "debug went last" so fetch wins the first tie
    end else begin
      instr_valid_o <= xfer;
      flush_o       <= is_jump;
      if (xfer) begin
        instr_o     <= acc.instr;
        grant_src_o <= acc.src;
        issue_cnt_o <= issue_cnt_o + 16'h0001;
        rr_last     <= acc.src;
      end
      if (is_jump) flush_adr_o <= acc.instr[12:0];
    end
  end

endmodule

// File: tb/tb_cpu0_fetch_sched.sv
// Directed bench for cpu0_fetch_sched: round-robin and fixed-priority instances.
module tb_cpu0_fetch_sched;

  logic        clk = 1'b0;
  logic        pon_rst_n_i;
  logic [15:0] fetch_instr_i, dbg_instr_i;
  logic        fetch_valid_i, dbg_valid_i, cpu_halt_i;

  logic        fetch_ready_o, dbg_ready_o, instr_valid_o, grant_src_o, flush_o;
  logic [15:0] instr_o, issue_cnt_o;
  logic [12:0] flush_adr_o;
  logic [1:0]  state_o;

  logic        fp_fetch_ready, fp_dbg_ready, fp_instr_valid, fp_grant_src, fp_flush;
  logic [15:0] fp_instr, fp_issue_cnt;
  logic [12:0] fp_flush_adr;
  logic [1:0]  fp_state;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu0_fetch_sched #(.RR_EN(1), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .pon_rst_n_i(pon_rst_n_i),
    .fetch_instr_i(fetch_instr_i), .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .dbg_instr_i(dbg_instr_i), .dbg_valid_i(dbg_valid_i), .dbg_ready_o(dbg_ready_o),
    .cpu_halt_i(cpu_halt_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .grant_src_o(grant_src_o), .flush_o(flush_o), .flush_adr_o(flush_adr_o),
    .issue_cnt_o(issue_cnt_o), .state_o(state_o)
  );

  cpu0_fetch_sched #(.RR_EN(0), .FLUSH_CYCLES(2)) dut_fp (
    .clk(clk), .pon_rst_n_i(pon_rst_n_i),
    .fetch_instr_i(fetch_instr_i), .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fp_fetch_ready),
    .dbg_instr_i(dbg_instr_i), .dbg_valid_i(dbg_valid_i), .dbg_ready_o(fp_dbg_ready),
    .cpu_halt_i(cpu_halt_i), .instr_o(fp_instr), .instr_valid_o(fp_instr_valid),
    .grant_src_o(fp_grant_src), .flush_o(fp_flush), .flush_adr_o(fp_flush_adr),
    .issue_cnt_o(fp_issue_cnt), .state_o(fp_state)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    fetch_instr_i = 16'h0000; dbg_instr_i = 16'h0000;
    fetch_valid_i = 1'b0; dbg_valid_i = 1'b0; cpu_halt_i = 1'b0;
  endtask

  // Reset, release, and step through the single IDLE cycle into ISSUE.
  task automatic go_issue();
    clear_inputs();
    pon_rst_n_i = 1'b0;
    tick();
    pon_rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    fetch_valid_i = 1'b1; dbg_valid_i = 1'b1;
    pon_rst_n_i = 1'b0;
    tick(); tick();
    checks++; if ({instr_o, instr_valid_o, grant_src_o, flush_o, flush_adr_o, issue_cnt_o, state_o} !== '0)
      $display("FAIL reset_values instr=%h v=%b src=%b fl=%b adr=%h cnt=%h st=%0d exp all 0",
               instr_o, instr_valid_o, grant_src_o, flush_o, flush_adr_o, issue_cnt_o, state_o);
    else passed++;
    pon_rst_n_i = 1'b1; #1;
    checks++; if (state_o !== 2'd0 || fetch_ready_o !== 1'b0 || dbg_ready_o !== 1'b0)
      $display("FAIL idle_after_release st=%0d fr=%b dr=%b exp st=0 fr=0 dr=0", state_o, fetch_ready_o, dbg_ready_o);
    else passed++;
    tick();
    checks++; if (state_o !== 2'd1 || fetch_ready_o !== 1'b1 || dbg_ready_o !== 1'b0)
      $display("FAIL issue_after_idle st=%0d fr=%b dr=%b exp st=1 fr=1 dr=0", state_o, fetch_ready_o, dbg_ready_o);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_instr;
    logic        exp_src;
    int          n = 0;
    go_issue();
    fetch_instr_i = 16'h1000; dbg_instr_i = 16'h3201;
    fetch_valid_i = 1'b1; dbg_valid_i = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      exp_src   = k[0];
      exp_instr = exp_src ? 16'h3201 : 16'h1000 + 16'(n);
      checks++; if (fetch_ready_o !== !exp_src || dbg_ready_o !== exp_src)
        $display("FAIL rr_ready[%0d] fr=%b dr=%b exp_src=%b", k, fetch_ready_o, dbg_ready_o, exp_src);
      else passed++;
      tick();
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== exp_instr || grant_src_o !== exp_src || issue_cnt_o !== 16'(k + 1))
        $display("FAIL rr_issue[%0d] v=%b instr=%h src=%b cnt=%h exp v=1 instr=%h src=%b cnt=%h",
                 k, instr_valid_o, instr_o, grant_src_o, issue_cnt_o, exp_instr, exp_src, 16'(k + 1));
      else passed++;
      if (!exp_src) begin
        n++;
        fetch_instr_i = 16'h1000 + 16'(n);
      end
      #1;
    end
    fetch_valid_i = 1'b0; dbg_valid_i = 1'b0;
    tick();
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 16'h3201 || issue_cnt_o !== 16'd6)
      $display("FAIL rr_idle_hold v=%b instr=%h cnt=%h exp v=0 instr=3201 cnt=0006", instr_valid_o, instr_o, issue_cnt_o);
    else passed++;
  endtask

  task automatic test_fixed_priority();
    go_issue();
    fetch_instr_i = 16'h1000; dbg_instr_i = 16'h3201;
    fetch_valid_i = 1'b1; dbg_valid_i = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (fp_fetch_ready !== 1'b0 || fp_dbg_ready !== 1'b1)
        $display("FAIL fp_ready[%0d] fr=%b dr=%b exp fr=0 dr=1", k, fp_fetch_ready, fp_dbg_ready);
      else passed++;
      tick();
      checks++; if (fp_instr_valid !== 1'b1 || fp_instr !== 16'h3201 || fp_grant_src !== 1'b1 || fp_issue_cnt !== 16'(k + 1))
        $display("FAIL fp_issue[%0d] v=%b instr=%h src=%b cnt=%h exp v=1 instr=3201 src=1 cnt=%h",
                 k, fp_instr_valid, fp_instr, fp_grant_src, fp_issue_cnt, 16'(k + 1));
      else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_jump();
    go_issue();
    fetch_instr_i = 16'h4ABC; fetch_valid_i = 1'b1; #1;
    checks++; if (fetch_ready_o !== 1'b1)
      $display("FAIL jump_accept fr=%b exp 1", fetch_ready_o);
    else passed++;
    tick();
    fetch_instr_i = 16'h0001; #1;
    checks++; if (flush_o !== 1'b1 || flush_adr_o !== 13'h0ABC || instr_valid_o !== 1'b1 || instr_o !== 16'h4ABC)
      $display("FAIL jump_flush fl=%b adr=%h v=%b instr=%h exp fl=1 adr=0abc v=1 instr=4abc",
               flush_o, flush_adr_o, instr_valid_o, instr_o);
    else passed++;
    checks++; if (state_o !== 2'd2 || fetch_ready_o !== 1'b0 || dbg_ready_o !== 1'b0)
      $display("FAIL jump_dead1 st=%0d fr=%b dr=%b exp st=2 fr=0 dr=0", state_o, fetch_ready_o, dbg_ready_o);
    else passed++;
    tick();
    checks++; if (state_o !== 2'd2 || fetch_ready_o !== 1'b0 || flush_o !== 1'b0 || instr_valid_o !== 1'b0)
      $display("FAIL jump_dead2 st=%0d fr=%b fl=%b v=%b exp st=2 fr=0 fl=0 v=0", state_o, fetch_ready_o, flush_o, instr_valid_o);
    else passed++;
    tick();
    checks++; if (state_o !== 2'd1 || fetch_ready_o !== 1'b1)
      $display("FAIL jump_resume st=%0d fr=%b exp st=1 fr=1", state_o, fetch_ready_o);
    else passed++;
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h0001 || flush_adr_o !== 13'h0ABC || issue_cnt_o !== 16'd2)
      $display("FAIL jump_after v=%b instr=%h adr=%h cnt=%h exp v=1 instr=0001 adr=0abc cnt=0002",
               instr_valid_o, instr_o, flush_adr_o, issue_cnt_o);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_halt_instr();
    go_issue();
    dbg_instr_i = 16'hF000; dbg_valid_i = 1'b1; #1;
    tick();
    dbg_instr_i = 16'h0002; fetch_valid_i = 1'b1; #1;
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'hF000 || grant_src_o !== 1'b1 || state_o !== 2'd3)
      $display("FAIL halt_issue v=%b instr=%h src=%b st=%0d exp v=1 instr=f000 src=1 st=3",
               instr_valid_o, instr_o, grant_src_o, state_o);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (state_o !== 2'd3 || fetch_ready_o !== 1'b0 || dbg_ready_o !== 1'b0 || instr_valid_o !== 1'b0)
        $display("FAIL halt_stay[%0d] st=%0d fr=%b dr=%b v=%b exp st=3 fr=0 dr=0 v=0",
                 k, state_o, fetch_ready_o, dbg_ready_o, instr_valid_o);
      else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_halt_input();
    go_issue();
    fetch_instr_i = 16'h0123; fetch_valid_i = 1'b1; cpu_halt_i = 1'b1; #1;
    checks++; if (fetch_ready_o !== 1'b0 || dbg_ready_o !== 1'b0)
      $display("FAIL haltin_ready fr=%b dr=%b exp 0 0", fetch_ready_o, dbg_ready_o);
    else passed++;
    tick();
    cpu_halt_i = 1'b0; #1;
    checks++; if (instr_valid_o !== 1'b0 || issue_cnt_o !== 16'd0 || state_o !== 2'd3)
      $display("FAIL haltin_state v=%b cnt=%h st=%0d exp v=0 cnt=0000 st=3", instr_valid_o, issue_cnt_o, state_o);
    else passed++;
    tick();
    checks++; if (state_o !== 2'd3 || fetch_ready_o !== 1'b0)
      $display("FAIL haltin_sticky st=%0d fr=%b exp st=3 fr=0", state_o, fetch_ready_o);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_halt_in_flush();
    go_issue();
    fetch_instr_i = 16'h4010; fetch_valid_i = 1'b1; #1;
    tick();
    fetch_valid_i = 1'b0; cpu_halt_i = 1'b1; #1;
    tick();
    cpu_halt_i = 1'b0; #1;
    checks++; if (state_o !== 2'd3)
      $display("FAIL flush_halt st=%0d exp 3", state_o);
    else passed++;
    tick();
    checks++; if (state_o !== 2'd3)
      $display("FAIL flush_halt_sticky st=%0d exp 3", state_o);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_counter_wrap();
    go_issue();
    fetch_instr_i = 16'h0000; fetch_valid_i = 1'b1;
    repeat (65535) tick();
    checks++; if (issue_cnt_o !== 16'hFFFF)
      $display("FAIL wrap_preload cnt=%h exp ffff", issue_cnt_o);
    else passed++;
    tick();
    checks++; if (issue_cnt_o !== 16'h0000 || instr_valid_o !== 1'b1)
      $display("FAIL wrap cnt=%h v=%b exp cnt=0000 v=1", issue_cnt_o, instr_valid_o);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_flush();
    go_issue();
    fetch_instr_i = 16'h4123; fetch_valid_i = 1'b1; #1;
    tick();
    fetch_valid_i = 1'b0; #1;
    checks++; if (state_o !== 2'd2 || flush_o !== 1'b1)
      $display("FAIL rmf_enter st=%0d fl=%b exp st=2 fl=1", state_o, flush_o);
    else passed++;
    #2 pon_rst_n_i = 1'b0; #1;
    checks++; if ({instr_o, instr_valid_o, grant_src_o, flush_o, flush_adr_o, issue_cnt_o, state_o} !== '0)
      $display("FAIL rmf_async instr=%h v=%b src=%b fl=%b adr=%h cnt=%h st=%0d exp all 0",
               instr_o, instr_valid_o, grant_src_o, flush_o, flush_adr_o, issue_cnt_o, state_o);
    else passed++;
    tick();
    pon_rst_n_i = 1'b1; #1;
    checks++; if (state_o !== 2'd0 || instr_valid_o !== 1'b0)
      $display("FAIL rmf_idle st=%0d v=%b exp st=0 v=0", state_o, instr_valid_o);
    else passed++;
    tick();
    checks++; if (state_o !== 2'd1 || instr_valid_o !== 1'b0 || issue_cnt_o !== 16'd0)
      $display("FAIL rmf_issue st=%0d v=%b cnt=%h exp st=1 v=0 cnt=0000", state_o, instr_valid_o, issue_cnt_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_jump();
    test_halt_instr();
    test_halt_input();
    test_halt_in_flush();
    test_reset_mid_flush();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
